batchnorm_act: RTL

// - Per-channel fixed-point batch-norm y = x*gamma + beta, with fused activation and valid/ready flow control.
// - Successor to the packed-parameter batch-norm stage of the final layer.
// - Parameters are written at runtime, not loaded from packed buses.
// - Sits between the pointwise-conv output and the next layer / classifier buffer.

---
 rtl/bn_pkg.sv | 14 +
 rtl/bn_param_rf.sv | 41 ++++
 rtl/batchnorm_act.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bn_pkg.sv
// Shared types and constants for the batch-norm + activation stage.
package bn_pkg;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_RELU6 = 2'd2,
        ACT_LEAKY = 2'd3
    } act_mode_e;

    localparam int unsigned LEAKY_SHIFT = 3;
    localparam int unsigned SAT_CNT_W   = 16;

endpackage

// File: rtl/bn_param_rf.sv
// Per-channel {gamma, beta} flop register file: one write port, one combinational read port.
module bn_param_rf #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FRAC     = 8,
    parameter int unsigned CHANNELS = 48,
    parameter int unsigned CH_W     = $clog2(CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [CH_W-1:0]         waddr,
    input  logic signed [WIDTH-1:0] wgamma,
    input  logic signed [WIDTH-1:0] wbeta,
    input  logic [CH_W-1:0]         raddr,
    output logic signed [WIDTH-1:0] rd_gamma_c,
    output logic signed [WIDTH-1:0] rd_beta_c
);

    localparam logic [CH_W:0]         CH_LIM    = (CH_W+1)'(CHANNELS);
    localparam logic signed [WIDTH-1:0] GAMMA_ONE = WIDTH'(2**FRAC);

    logic signed [WIDTH-1:0] gamma_q [CHANNELS];
    logic signed [WIDTH-1:0] beta_q  [CHANNELS];

    // Out-of-range write addresses are silently ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                gamma_q[i] <= GAMMA_ONE;
                beta_q[i]  <= '0;
            end
        end else if (we && ({1'b0, waddr} < CH_LIM)) begin
            gamma_q[waddr] <= wgamma;
            beta_q[waddr]  <= wbeta;
        end
    end

    assign rd_gamma_c = ({1'b0, raddr} < CH_LIM) ? gamma_q[raddr] : GAMMA_ONE;
    assign rd_beta_c  = ({1'b0, raddr} < CH_LIM) ? beta_q[raddr]  : '0;

endmodule

// File: rtl/batchnorm_act.sv
// Three-stage per-channel y = x*gamma + beta with saturation, fused activation and valid/ready flow.
module batchnorm_act
    import bn_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FRAC     = 8,
    parameter int unsigned CHANNELS = 48,
    localparam int unsigned CH_W    = $clog2(CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic [CH_W-1:0]         channel_in,
    input  logic [1:0]              act_mode,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_addr,
    input  logic signed [WIDTH-1:0] cfg_gamma,
    input  logic signed [WIDTH-1:0] cfg_beta,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] y_out,
    output logic [CH_W-1:0]         channel_out,
    output logic                    err_chan,
    input  logic                    err_clr,
    output logic [SAT_CNT_W-1:0]    sat_cnt
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = 2 * WIDTH + 1;
    localparam logic [CH_W:0]        CH_LIM = (CH_W+1)'(CHANNELS);
    localparam logic signed [SW-1:0] MAX_S  = SW'(2**(WIDTH-1) - 1);
    localparam logic signed [SW-1:0] MIN_S  = ~MAX_S;
    localparam logic signed [SW-1:0] ROUND  = SW'(2**(FRAC-1));
    localparam logic signed [SW-1:0] C6_S   = SW'(6 * 2**FRAC);
    localparam logic signed [WIDTH-1:0] C6  = (C6_S > MAX_S) ? WIDTH'(MAX_S) : WIDTH'(C6_S);

    logic advance, accept, chan_ok;
    logic signed [WIDTH-1:0] rd_gamma, rd_beta;

    logic                    s1_valid;
    logic signed [WIDTH-1:0] s1_x, s1_gamma, s1_beta;
    logic [CH_W-1:0]         s1_ch;
    act_mode_e               s1_mode;

    logic                    s2_valid;
    logic signed [PW-1:0]    s2_p;
    logic signed [WIDTH-1:0] s2_beta;
    logic [CH_W-1:0]         s2_ch;
    act_mode_e               s2_mode;

    logic signed [SW-1:0]    s3_round, s3_sum;
    logic signed [WIDTH-1:0] s3_clamp, s3_act;
    logic                    s3_sat;

    assign advance  = ~(out_valid & ~out_ready);
    assign in_ready = advance;
    assign accept   = in_valid & advance;
    assign chan_ok  = {1'b0, channel_in} < CH_LIM;

    bn_param_rf #(
        .WIDTH    (WIDTH),
        .FRAC     (FRAC),
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_param_rf (
        .clk        (clk),
        .rst        (rst),
        .we         (cfg_we),
        .waddr      (cfg_addr),
        .wgamma     (cfg_gamma),
        .wbeta      (cfg_beta),
        .raddr      (channel_in),
        .rd_gamma_c (rd_gamma),
        .rd_beta_c  (rd_beta)
    );

    // S3 datapath: round half up, add bias, clamp, then activate the clamped value.
    always_comb begin
        s3_round = (SW'(s2_p) + ROUND) >>> FRAC;
        s3_sum   = s3_round + SW'(s2_beta);
        s3_sat   = 1'b0;
        s3_clamp = WIDTH'(s3_sum);
        if (s3_sum > MAX_S) begin
            s3_clamp = WIDTH'(MAX_S);
            s3_sat   = 1'b1;
        end else if (s3_sum < MIN_S) begin
            s3_clamp = WIDTH'(MIN_S);
            s3_sat   = 1'b1;
        end
        s3_act = s3_clamp;
        case (s2_mode)
            ACT_NONE:  s3_act = s3_clamp;
            ACT_RELU:  s3_act = s3_clamp[WIDTH-1] ? '0 : s3_clamp;
            ACT_RELU6: begin
                if (s3_clamp[WIDTH-1])  s3_act = '0;
                else if (s3_clamp > C6) s3_act = C6;
                else                    s3_act = s3_clamp;
            end
            ACT_LEAKY: s3_act = s3_clamp[WIDTH-1] ? (s3_clamp >>> LEAKY_SHIFT) : s3_clamp;
            default:   s3_act = s3_clamp;
        endcase
    end

    // Whole pipe moves together; a stall freezes every stage. Bad-channel beats never enter S1 valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid    <= 1'b0;
            s1_x        <= '0;
            s1_gamma    <= '0;
            s1_beta     <= '0;
            s1_ch       <= '0;
            s1_mode     <= ACT_NONE;
            s2_valid    <= 1'b0;
            s2_p        <= '0;
            s2_beta     <= '0;
            s2_ch       <= '0;
            s2_mode     <= ACT_NONE;
            out_valid   <= 1'b0;
            y_out       <= '0;
            channel_out <= '0;
        end else if (advance) begin
            s1_valid <= accept & chan_ok;
            if (accept) begin
                s1_x     <= x_in;
                s1_ch    <= channel_in;
                s1_mode  <= act_mode_e'(act_mode);
                s1_gamma <= rd_gamma;
                s1_beta  <= rd_beta;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_p    <= PW'(s1_x) * PW'(s1_gamma);
                s2_beta <= s1_beta;
                s2_ch   <= s1_ch;
                s2_mode <= s1_mode;
            end
            out_valid <= s2_valid;
            if (s2_valid) begin
                y_out       <= s3_act;
                channel_out <= s2_ch;
            end
        end
    end

    // Sticky error flag and saturating clamp counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_chan <= 1'b0;
            sat_cnt  <= '0;
        end else begin
            if (accept && !chan_ok) err_chan <= 1'b1;
            else if (err_clr)       err_chan <= 1'b0;
            if (err_clr)
                sat_cnt <= '0;
            else if (advance && s2_valid && s3_sat && (sat_cnt != '1))
                sat_cnt <= sat_cnt + SAT_CNT_W'(1);
        end
    end

endmodule
